// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer: op codes, register map, FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package softmax_pkg;
   localparam int ADR_W = 18;
   localparam int DAT_W = 32;

   // Datapath op, constant for the whole of a pass
   typedef enum logic [1:0] {
      OP_MAX    = 2'd0,
      OP_EXPSUM = 2'd1,
      OP_NORM   = 2'd2
   } dp_op_t;

   // Register word offsets from REG_BASE
   localparam logic [2:0] OFS_CTRL = 3'd0;
   localparam logic [2:0] OFS_STAT = 3'd1;
   localparam logic [2:0] OFS_BASE = 3'd2;
   localparam logic [2:0] OFS_LEN  = 3'd3;
   localparam logic [2:0] OFS_PROG = 3'd4;

   // CTRL and STAT bit positions
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_ERR    = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } seq_state_t;

   // True when the vector would run past the top of the address space
   function automatic logic range_bad(input logic [ADR_W-1:0] base, input logic [ADR_W:0] len_ext);
      return ({1'b0, base} + len_ext) > {1'b1, {ADR_W{1'b0}}};
   endfunction
endpackage

// File: rtl/softmax_seq_regs.sv
// Host register file: address decode, BASE/LEN/IRQ_EN storage, sticky DONE/ERR, read mux.
// Latency: writes take effect at the strobe edge; RDATA is registered, valid 1 cycle after RD.
// Backpressure: none; every WR/RD strobe completes in one cycle.
module softmax_seq_regs
   import softmax_pkg::*;
#(
   parameter logic [ADR_W-1:0] REG_BASE = 18'h3FFF0,
   parameter int               LEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic             rd,
   input  logic [ADR_W-1:0] adr,
   input  logic [DAT_W-1:0] wdata,
   input  logic             busy,
   input  logic             done_set,
   input  logic             err_set,
   input  logic [1:0]       pass,
   input  logic [LEN_W-1:0] idx,
   output logic [DAT_W-1:0] rdata,
   output logic [ADR_W-1:0] base,
   output logic [LEN_W-1:0] len,
   output logic             start_req,
   output logic             abort_req,
   output logic             irq
);
   logic [ADR_W-1:0] ofs;
   logic             hit;
   logic [2:0]       sel;
   logic             wr_ctrl, wr_stat, wr_base, wr_len;
   logic             irq_en, done_q, err_q;
   logic [DAT_W-1:0] rd_mux;
   logic             unused_wdata;

   assign ofs     = adr - REG_BASE;
   assign hit     = (adr >= REG_BASE) && (ofs <= ADR_W'(OFS_PROG));
   assign sel     = ofs[2:0];
   assign wr_ctrl = wr && hit && (sel == OFS_CTRL);
   assign wr_stat = wr && hit && (sel == OFS_STAT);
   assign wr_base = wr && hit && (sel == OFS_BASE);
   assign wr_len  = wr && hit && (sel == OFS_LEN);

   // ABORT in the same write as START suppresses the START
   assign start_req = wr_ctrl && wdata[CTRL_START] && !wdata[CTRL_ABORT];
   assign abort_req = wr_ctrl && wdata[CTRL_ABORT];
   assign irq       = done_q && irq_en;

   assign unused_wdata = ^wdata[DAT_W-1:ADR_W];

   // Read mux over current (pre-write) register values; unmapped addresses read 0
   always_comb begin
      rd_mux = '0;
      if (hit) begin
         case (sel)
            OFS_CTRL: rd_mux[CTRL_IRQ_EN] = irq_en;
            OFS_STAT: begin
               rd_mux[STAT_BUSY] = busy;
               rd_mux[STAT_DONE] = done_q;
               rd_mux[STAT_ERR]  = err_q;
            end
            OFS_BASE: rd_mux[ADR_W-1:0]   = base;
            OFS_LEN:  rd_mux[LEN_W-1:0]   = len;
            OFS_PROG: rd_mux[LEN_W+1:0]   = {pass, idx};
            default:  rd_mux = '0;
         endcase
      end
   end

   // Register updates; BASE/LEN frozen while a run is active, hardware set beats W1C
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
         base   <= '0;
         len    <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rdata  <= '0;
      end else begin
         if (wr_ctrl)
            irq_en <= wdata[CTRL_IRQ_EN];
         if (wr_base && !busy)
            base <= wdata[ADR_W-1:0];
         if (wr_len && !busy)
            len <= wdata[LEN_W-1:0];
         if (done_set)
            done_q <= 1'b1;
         else if (wr_stat && wdata[STAT_DONE])
            done_q <= 1'b0;
         if (err_set)
            err_q <= 1'b1;
         else if (wr_stat && wdata[STAT_ERR])
            err_q <= 1'b0;
         if (rd)
            rdata <= rd_mux;
      end
   end
endmodule

// File: rtl/softmax_seq_ctrl.sv
// Softmax sequencer: runs MAX, EXPSUM, NORM element passes over BASE..BASE+LEN-1, draining between passes.
// Latency: first request the cycle after START; runtime 3*LEN + 3*(drain+1) + 1 cycles with no stalls.
// Backpressure: request held stable while DP_READY is low; next pass waits for DP_BUSY to clear.
module softmax_seq_ctrl
   import softmax_pkg::*;
#(
   parameter logic [ADR_W-1:0] REG_BASE = 18'h3FFF0,
   parameter int               LEN_W    = 16
) (
   input  logic             CLK,
   input  logic             RESET_X,
   input  logic             WR,
   input  logic             RD,
   input  logic [ADR_W-1:0] ADR,
   input  logic [DAT_W-1:0] WDATA,
   output logic [DAT_W-1:0] RDATA,
   output logic             DP_VALID,
   input  logic             DP_READY,
   output logic [1:0]       DP_OP,
   output logic [ADR_W-1:0] DP_ADR,
   output logic             DP_FIRST,
   output logic             DP_LAST,
   input  logic             DP_BUSY,
   output logic             IRQ
);
   seq_state_t       state;
   dp_op_t           pass;
   logic [LEN_W-1:0] idx;
   logic [ADR_W-1:0] base;
   logic [LEN_W-1:0] len;
   logic             start_req, abort_req;
   logic             busy, done_set, err_set, params_bad;

   assign busy       = (state != ST_IDLE);
   assign done_set   = (state == ST_FIN);
   assign params_bad = (len == '0) || range_bad(base, (ADR_W+1)'(len));
   assign err_set    = start_req && (state == ST_IDLE) && params_bad;
   assign DP_OP      = pass;

   softmax_seq_regs #(
      .REG_BASE (REG_BASE),
      .LEN_W    (LEN_W)
   ) u_regs (
      .clk       (CLK),
      .rst_n     (RESET_X),
      .wr        (WR),
      .rd        (RD),
      .adr       (ADR),
      .wdata     (WDATA),
      .busy      (busy),
      .done_set  (done_set),
      .err_set   (err_set),
      .pass      (pass),
      .idx       (idx),
      .rdata     (RDATA),
      .base      (base),
      .len       (len),
      .start_req (start_req),
      .abort_req (abort_req),
      .irq       (IRQ)
   );

   // Pass sequencer with registered datapath request; ABORT overrides everything
   always_ff @(posedge CLK or negedge RESET_X) begin
      if (!RESET_X) begin
         state    <= ST_IDLE;
         pass     <= OP_MAX;
         idx      <= '0;
         DP_VALID <= 1'b0;
         DP_ADR   <= '0;
         DP_FIRST <= 1'b0;
         DP_LAST  <= 1'b0;
      end else if (abort_req) begin
         state    <= ST_IDLE;
         DP_VALID <= 1'b0;
         DP_FIRST <= 1'b0;
         DP_LAST  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_req && !params_bad) begin
                  state    <= ST_RUN;
                  pass     <= OP_MAX;
                  idx      <= '0;
                  DP_VALID <= 1'b1;
                  DP_ADR   <= base;
                  DP_FIRST <= 1'b1;
                  DP_LAST  <= (len == LEN_W'(1));
               end
            end
            ST_RUN: begin
               if (DP_READY) begin
                  if (DP_LAST) begin
                     state    <= ST_DRAIN;
                     DP_VALID <= 1'b0;
                     DP_FIRST <= 1'b0;
                     DP_LAST  <= 1'b0;
                  end else begin
                     idx      <= idx + LEN_W'(1);
                     DP_ADR   <= DP_ADR + ADR_W'(1);
                     DP_FIRST <= 1'b0;
                     DP_LAST  <= ((idx + LEN_W'(1)) == (len - LEN_W'(1)));
                  end
               end
            end
            ST_DRAIN: begin
               if (!DP_BUSY) begin
                  idx <= '0;
                  if (pass == OP_NORM) begin
                     state <= ST_FIN;
                  end else begin
                     state    <= ST_RUN;
                     pass     <= (pass == OP_MAX) ? OP_EXPSUM : OP_NORM;
                     DP_VALID <= 1'b1;
                     DP_ADR   <= base;
                     DP_FIRST <= 1'b1;
                     DP_LAST  <= (len == LEN_W'(1));
                  end
               end
            end
            ST_FIN: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Directed bench for softmax_seq_ctrl: register access, pass sequencing, stalls, drain, errors, abort, IRQ.
// Latency: inputs driven 1ns after the rising edge, outputs sampled there or on the falling edge.
// Backpressure: DP_READY/DP_BUSY patterns are generated by the bench.
module tb_softmax_seq_ctrl;
   localparam logic [17:0] A_CTRL = 18'h3FFF0;
   localparam logic [17:0] A_STAT = 18'h3FFF1;
   localparam logic [17:0] A_BASE = 18'h3FFF2;
   localparam logic [17:0] A_LEN  = 18'h3FFF3;
   localparam logic [17:0] A_UNM  = 18'h3FFF5;

   logic        CLK, RESET_X, WR, RD, DP_READY, DP_BUSY;
   logic [17:0] ADR;
   logic [31:0] WDATA, RDATA;
   logic        DP_VALID, DP_FIRST, DP_LAST, IRQ;
   logic [1:0]  DP_OP;
   logic [17:0] DP_ADR;

   int n_checks = 0;
   int n_errors = 0;
   int valid_cnt = 0;

   logic [1:0]  hs_op[$];
   logic [17:0] hs_adr[$];
   logic        hs_first[$];
   logic        hs_last[$];
   logic        stall_prev = 1'b0;
   logic [17:0] stall_adr;
   logic [1:0]  stall_op;

   softmax_seq_ctrl dut (
      .CLK(CLK), .RESET_X(RESET_X), .WR(WR), .RD(RD), .ADR(ADR), .WDATA(WDATA), .RDATA(RDATA),
      .DP_VALID(DP_VALID), .DP_READY(DP_READY), .DP_OP(DP_OP), .DP_ADR(DP_ADR),
      .DP_FIRST(DP_FIRST), .DP_LAST(DP_LAST), .DP_BUSY(DP_BUSY), .IRQ(IRQ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic reg_wr(input logic [17:0] a, input logic [31:0] d);
      WR = 1'b1; ADR = a; WDATA = d;
      tick();
      WR = 1'b0;
   endtask

   task automatic reg_rd(input logic [17:0] a, output logic [31:0] d);
      RD = 1'b1; ADR = a;
      tick();
      RD = 1'b0;
      d = RDATA;
   endtask

   task automatic clear_log();
      hs_op.delete(); hs_adr.delete(); hs_first.delete(); hs_last.delete();
   endtask

   // Handshake log and stall-stability monitor on the falling edge
   always @(negedge CLK) begin
      if (RESET_X) begin
         if (DP_VALID) valid_cnt++;
         if (stall_prev && DP_VALID) begin
            chk("stall_adr", 32'(DP_ADR), 32'(stall_adr));
            chk("stall_op", 32'(DP_OP), 32'(stall_op));
         end
         if (DP_VALID && DP_READY) begin
            hs_op.push_back(DP_OP); hs_adr.push_back(DP_ADR);
            hs_first.push_back(DP_FIRST); hs_last.push_back(DP_LAST);
         end
         stall_prev = DP_VALID && !DP_READY;
         stall_adr  = DP_ADR;
         stall_op   = DP_OP;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Expected: three passes, op p, addresses base..base+len-1, FIRST/LAST at the ends
   task automatic verify_log(input int base, input int len);
      chk("hs_count", 32'(hs_adr.size()), 32'(3 * len));
      for (int i = 0; i < hs_adr.size() && i < 3 * len; i++) begin
         chk("hs_op",    32'(hs_op[i]),    32'(i / len));
         chk("hs_adr",   32'(hs_adr[i]),   32'(base + i % len));
         chk("hs_first", 32'(hs_first[i]), 32'((i % len) == 0));
         chk("hs_last",  32'(hs_last[i]),  32'((i % len) == len - 1));
      end
   endtask

   // Ticks until IRQ; mode 1 gives DP_READY 1-of-3 during MAX; busy_len holds DP_BUSY after MAX LAST
   task automatic run_until_irq(input int mode, input int busy_len, output int n, output int gap);
      int   busy_left = 0;
      int   h_edge = -1;
      int   first_exp = -1;
      logic will_last_max;
      n = 0;
      while (!IRQ && n < 400) begin
         DP_READY = (mode == 1 && DP_OP == 2'd0) ? (n % 3 == 2) : 1'b1;
         will_last_max = DP_VALID && DP_READY && DP_LAST && (DP_OP == 2'd0);
         tick();
         n++;
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) DP_BUSY = 1'b0;
         end
         if (will_last_max) begin
            h_edge = n;
            if (busy_len > 0) begin
               DP_BUSY = 1'b1;
               busy_left = busy_len;
            end
         end
         if (DP_VALID && DP_OP == 2'd1 && first_exp < 0) first_exp = n;
      end
      chk("run_completes", 32'(n < 400), 32'd1);
      gap = (h_edge >= 0 && first_exp >= 0) ? first_exp - h_edge : -1;
      DP_READY = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int n, gap;
      RESET_X = 1'b0; WR = 1'b0; RD = 1'b0; ADR = '0; WDATA = '0; DP_READY = 1'b0; DP_BUSY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_dp_valid", 32'(DP_VALID), 32'd0);
      chk("rst_dp_adr", 32'(DP_ADR), 32'd0);
      chk("rst_irq", 32'(IRQ), 32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      RESET_X = 1'b1;
      tick();

      // 1: reset values, read-back, unmapped read, simultaneous WR+RD
      reg_rd(A_STAT, d); chk("t1_stat", d, 32'd0);
      reg_rd(A_BASE, d); chk("t1_base0", d, 32'd0);
      reg_rd(A_LEN, d);  chk("t1_len0", d, 32'd0);
      reg_wr(A_BASE, 32'h100);
      reg_wr(A_LEN, 32'd4);
      reg_rd(A_BASE, d); chk("t1_base", d, 32'h100);
      reg_rd(A_LEN, d);  chk("t1_len", d, 32'd4);
      reg_rd(A_UNM, d);  chk("t1_unmapped", d, 32'd0);
      WR = 1'b1; RD = 1'b1; ADR = A_BASE; WDATA = 32'h123;
      tick();
      WR = 1'b0; RD = 1'b0;
      chk("t1_wr_rd_old", RDATA, 32'h100);
      reg_rd(A_BASE, d); chk("t1_wr_rd_new", d, 32'h123);
      reg_wr(A_BASE, 32'h100);

      // 2: full run, no backpressure, IRQ enabled
      DP_READY = 1'b1; DP_BUSY = 1'b0;
      clear_log();
      reg_wr(A_CTRL, 32'h5);
      chk("t2_first_valid", 32'(DP_VALID), 32'd1);
      chk("t2_first_adr", 32'(DP_ADR), 32'h100);
      chk("t2_first_flag", 32'(DP_FIRST), 32'd1);
      run_until_irq(0, 0, n, gap);
      chk("t2_runtime", 32'(n), 32'd16);
      chk("t2_drain_gap", 32'(gap), 32'd1);
      verify_log(32'h100, 4);
      reg_rd(A_STAT, d); chk("t2_stat_done", d, 32'h2);
      reg_wr(A_STAT, 32'h2);
      chk("t2_irq_clr", 32'(IRQ), 32'd0);

      // 3: READY 1-of-3 during MAX, DP_BUSY held 5 cycles after MAX LAST
      reg_wr(A_BASE, 32'h200);
      clear_log();
      reg_wr(A_CTRL, 32'h5);
      run_until_irq(1, 5, n, gap);
      chk("t3_drain_gap", 32'(gap), 32'd6);
      verify_log(32'h200, 4);
      reg_wr(A_STAT, 32'h2);

      // 4: error starts
      reg_wr(A_LEN, 32'd0);
      n = valid_cnt;
      reg_wr(A_CTRL, 32'h1);
      tick(); tick();
      reg_rd(A_STAT, d); chk("t4_err_len0", d, 32'h4);
      chk("t4_no_valid_len0", 32'(valid_cnt - n), 32'd0);
      reg_wr(A_STAT, 32'h4);
      reg_rd(A_STAT, d); chk("t4_err_w1c", d, 32'd0);
      reg_wr(A_BASE, 32'h3FFFE);
      reg_wr(A_LEN, 32'd4);
      n = valid_cnt;
      reg_wr(A_CTRL, 32'h1);
      tick(); tick();
      reg_rd(A_STAT, d); chk("t4_err_range", d, 32'h4);
      chk("t4_no_valid_range", 32'(valid_cnt - n), 32'd0);
      reg_wr(A_STAT, 32'h4);

      // 5: ABORT at EXPSUM idx 2, then clean restart
      reg_wr(A_BASE, 32'h300);
      clear_log();
      reg_wr(A_CTRL, 32'h5);
      n = 0;
      while (!(DP_VALID && DP_OP == 2'd1 && DP_ADR == 18'h302) && n < 100) begin
         tick();
         n++;
      end
      chk("t5_reach_idx2", 32'(n < 100), 32'd1);
      DP_READY = 1'b0;
      reg_wr(A_CTRL, 32'h6);
      chk("t5_valid_drop", 32'(DP_VALID), 32'd0);
      chk("t5_hs_before_abort", 32'(hs_adr.size()), 32'd6);
      reg_rd(A_STAT, d); chk("t5_stat", d, 32'd0);
      chk("t5_irq", 32'(IRQ), 32'd0);
      DP_READY = 1'b1;
      clear_log();
      reg_wr(A_CTRL, 32'h5);
      run_until_irq(0, 0, n, gap);
      verify_log(32'h300, 4);
      reg_wr(A_STAT, 32'h2);

      // 6: LEN=1, IRQ with DONE, writes while busy ignored
      reg_wr(A_BASE, 32'h050);
      reg_wr(A_LEN, 32'd1);
      clear_log();
      reg_wr(A_CTRL, 32'h5);
      reg_wr(A_BASE, 32'h777);
      reg_wr(A_CTRL, 32'h5);
      run_until_irq(0, 0, n, gap);
      chk("t6_irq", 32'(IRQ), 32'd1);
      reg_rd(A_STAT, d); chk("t6_stat_done", d, 32'h2);
      reg_wr(A_STAT, 32'h2);
      chk("t6_irq_clr", 32'(IRQ), 32'd0);
      repeat (5) tick();
      verify_log(32'h050, 1);
      reg_rd(A_BASE, d); chk("t6_base_kept", d, 32'h050);

      // Async reset mid-pass
      reg_wr(A_LEN, 32'd4);
      reg_wr(A_CTRL, 32'h5);
      tick();
      RESET_X = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(DP_VALID), 32'd0);
      chk("rst_mid_irq", 32'(IRQ), 32'd0);
      #5;
      RESET_X = 1'b1;
      tick();
      reg_rd(A_STAT, d); chk("rst_mid_stat", d, 32'd0);
      reg_rd(A_BASE, d); chk("rst_mid_base", d, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
